poly_basemul_acc: RTL and testbench
===================================

Name: poly_basemul_acc

Overview:
- Parametrised successor of the two-lane Kyber NTT-domain pointwise multiplier.
- Computes r = sum over k < poly_cnt of basemul(A[k], B[k]) over all 128 coefficient pairs, with LANES pairs per cycle, then applies a centered Barrett reduction.
- poly_cnt = 1 gives a plain poly_basemul_montgomery. poly_cnt = K gives polyvec_basemul_acc_montgomery for the matrix-vector product.
- Sits between the NTT and INTT stages. It reads A and B from external 1-cycle-latency RAMs and writes r to an external RAM.

Parameters:
- LANES, 2, coefficient pairs processed per cycle; power of two, 1..8.
- K_MAX, 4, maximum polynomials accumulated (Kyber768 uses 3).
- W, 16, signed coefficient width.
- GRP_W, $clog2(128/LANES), pair-group index width.
- K_W, $clog2(K_MAX), polynomial index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- poly_cnt  in  K_W+1  number of polynomial pairs to accumulate; sampled on the accepted start.
- a_addr  out  K_W+GRP_W  address {k, g} into A RAM.
- b_addr  out  K_W+GRP_W  address {k, g} into B RAM.
- a_re  out  1  A/B read enable.
- a_rdata  in  LANES*2*W  A word: lane l occupies bits [l*32 +: 32], with the low half = coefficient 0 and the high half = coefficient 1.
- b_rdata  in  LANES*2*W  B word, same packing as a_rdata.
- r_addr  out  GRP_W  output group address.
- r_wdata  out  LANES*2*W  output word, same packing as a_rdata.
- r_we  out  1  output write strobe.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, and the pipeline valid bits are cleared. Reset mid-operation discards in-flight data; no r_we is asserted after reset.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE on start when 1 <= poly_cnt <= K_MAX.
  - poly_cnt > K_MAX is clamped to K_MAX.
  - poly_cnt = 0 goes IDLE -> DONE: no reads, no writes, done pulses one cycle after start.
  - start while busy is ignored.
- ISSUE:
  - One read per cycle with a_re = 1. Loop order is group-major, k-minor: (g=0,k=0..n-1), (g=1,k=0..n-1), and so on.
  - a_addr = b_addr = {k, g}.
  - After (G-1, n-1), where G = 128/LANES, the FSM goes to DRAIN.
- DRAIN: waits until the last write has issued, then goes to DONE. DONE lasts one cycle (done = 1) and returns to IDLE.
- Pipeline and latency:
  - rdata is valid in cycle t+1 for a read issued in cycle t.
  - basemul_pipe latency is 4 cycles.
  - Accumulate takes 1 cycle; Barrett reduction plus the output register take 1 cycle.
  - r_we for group g asserts exactly 7 cycles after the issue of (g, n-1). r_addr = g on that cycle.
  - Total runtime: done asserts G*n + 7 cycles after the start cycle, counting the start cycle as cycle 0.
- Arithmetic, per lane, for pair p = g*LANES + l:
  - fqmul(x,y) = montgomery_reduce(x*y) = (x*y - t*Q) >> 16, where t = low 16 bits of (x*y*QINV), read as signed.
  - Q = 3329 and QINV = -3327.
  - zeta = ZETAS[64 + p/2], negated when p is odd.
  - r0 = fqmul(fqmul(a1,b1), zeta) + fqmul(a0,b0).
  - r1 = fqmul(a0,b1) + fqmul(a1,b0).
- Accumulator:
  - 20-bit signed per coefficient, so no overflow for K_MAX <= 8.
  - Cleared (loaded, not added) on k = 0.
- Output: barrett(v) = v - ((20159*v + 2^25) >>> 26)*Q, truncated to W bits. The result lies in [-1664, 1664].

Decomposition:
- Package kyber_pkg: Q, QINV, BARRETT_V (20159), MONT_R (2285), and the 128-entry signed ZETAS constant array.
- Package functions: montgomery_reduce and barrett_reduce.
- Sub-module basemul_pipe holds one lane.
  - Inputs: a0, a1, b0, b1, zeta, in_valid.
  - Outputs: r0, r1, out_valid.
  - Fixed 4-stage pipeline with no stall.
  - Instantiated LANES times in a generate loop.
- The top level holds the FSM, address counters, valid shift register, accumulators and reduction.

Test Plan:
- Identity: LANES=2, n=1, every pair A=(2285,0), B=(5,7) -> every r pair = (5,7); 64 writes at addresses 0..63; done at cycle 71.
- Zeta sign: A=B=(0,2285) for all pairs -> pair 0 = (-1103,0), pair 1 = (1103,0). Pairs 2 and 3 = (ZETAS[65],0) and (-ZETAS[65],0), i.e. (430,0) and (-430,0).
- Accumulate: n=3, every A[k]=(2285,0), B[k]=(5,7) -> (15,21). Read order observed on a_addr: {0,0},{1,0},{2,0},{0,1},...
- Reduction wrap: n=3, each term gives r0 = 1664 -> output 4992 - 3329 = 1663; each term gives r0 = -1664 -> output -1663.
- Handshake: start pulsed again while busy -> ignored, only 192 reads occur. poly_cnt=0 -> done the next cycle with no a_re or r_we. poly_cnt=7 with K_MAX=4 -> 4 reads per group.
- Reset mid-run: assert rst at cycle 50 -> outputs 0 immediately, no r_we afterwards. A fresh start after release completes normally.

Source files
------------

// File: rtl/kyber_pkg.sv
// Kyber field constants, zeta table and the Montgomery/Barrett
// reductions shared by the pointwise-multiply datapath.
package kyber_pkg;

  localparam int Q         = 3329;
  localparam int QINV      = -3327;
  localparam int BARRETT_V = 20159;
  localparam int MONT_R    = 2285;

  localparam int ZETAS [128] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  // Side-band that travels alongside the multiplier pipeline.
  typedef struct packed {
    logic       vld;
    logic       first;
    logic       last;
    logic [6:0] grp;
  } meta_t;

  function automatic logic signed [15:0] montgomery_reduce(
    input logic signed [31:0] a
  );
    logic signed [31:0] u;
    logic signed [15:0] t;
    logic signed [31:0] d;
    u = a * QINV;
    t = 16'(u);
    d = a - t * Q;
    return 16'(d >>> 16);
  endfunction

  function automatic logic signed [15:0] fqmul(
    input logic signed [15:0] x,
    input logic signed [15:0] y
  );
    return montgomery_reduce(32'(x) * 32'(y));
  endfunction

  function automatic logic signed [15:0] barrett_reduce(
    input logic signed [19:0] v
  );
    logic signed [39:0] vx;
    logic signed [39:0] m;
    logic signed [39:0] r;
    vx = 40'(v);
    m  = (vx * 40'(BARRETT_V) + 40'sd33554432) >>> 26;
    r  = vx - m * 40'(Q);
    return 16'(r);
  endfunction

endpackage

// File: rtl/basemul_pipe.sv
// One lane of the degree-1 basemul: four register stages,
// no stall, valid bit carried alongside the data.
module basemul_pipe
  import kyber_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] a0,
  input  logic signed [W-1:0] a1,
  input  logic signed [W-1:0] b0,
  input  logic signed [W-1:0] b1,
  input  logic signed [W-1:0] zeta,
  input  logic                in_valid,
  output logic signed [W-1:0] r0,
  output logic signed [W-1:0] r1,
  output logic                out_valid
);

  logic [3:0] v_q, v_d;
  logic signed [W-1:0] m11_q, m11_d, m00_q, m00_d;
  logic signed [W-1:0] m01_q, m01_d, m10_q, m10_d;
  logic signed [W-1:0] z_q, z_d;
  logic signed [W-1:0] mz_q, mz_d, c00_q, c00_d, s1_q, s1_d;
  logic signed [W-1:0] p0_q, p0_d, p1_q, p1_d;
  logic signed [W-1:0] o0_q, o0_d, o1_q, o1_d;

  always_comb begin
    v_d   = {v_q[2:0], in_valid};
    m11_d = fqmul(a1, b1);
    m00_d = fqmul(a0, b0);
    m01_d = fqmul(a0, b1);
    m10_d = fqmul(a1, b0);
    z_d   = zeta;
    mz_d  = fqmul(m11_q, z_q);
    c00_d = m00_q;
    s1_d  = m01_q + m10_q;
    p0_d  = mz_q + c00_q;
    p1_d  = s1_q;
    o0_d  = p0_q;
    o1_d  = p1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      m11_q <= '0;
      m00_q <= '0;
      m01_q <= '0;
      m10_q <= '0;
      z_q   <= '0;
      mz_q  <= '0;
      c00_q <= '0;
      s1_q  <= '0;
      p0_q  <= '0;
      p1_q  <= '0;
      o0_q  <= '0;
      o1_q  <= '0;
    end else begin
      v_q   <= v_d;
      m11_q <= m11_d;
      m00_q <= m00_d;
      m01_q <= m01_d;
      m10_q <= m10_d;
      z_q   <= z_d;
      mz_q  <= mz_d;
      c00_q <= c00_d;
      s1_q  <= s1_d;
      p0_q  <= p0_d;
      p1_q  <= p1_d;
      o0_q  <= o0_d;
      o1_q  <= o1_d;
    end
  end

  assign r0        = o0_q;
  assign r1        = o1_q;
  assign out_valid = v_q[3];

endmodule

// File: rtl/poly_basemul_acc.sv
// NTT-domain pointwise multiply-accumulate over up to K_MAX
// polynomial pairs, LANES coefficient pairs per cycle.
module poly_basemul_acc
  import kyber_pkg::*;
#(
  parameter int LANES = 2,
  parameter int K_MAX = 4,
  parameter int W     = 16,
  parameter int GRP_W = $clog2(128 / LANES),
  parameter int K_W   = $clog2(K_MAX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [K_W:0]             poly_cnt,
  output logic [K_W+GRP_W-1:0]     a_addr,
  output logic [K_W+GRP_W-1:0]     b_addr,
  output logic                     a_re,
  input  logic [LANES*2*W-1:0]     a_rdata,
  input  logic [LANES*2*W-1:0]     b_rdata,
  output logic [GRP_W-1:0]         r_addr,
  output logic [LANES*2*W-1:0]     r_wdata,
  output logic                     r_we,
  output logic                     busy,
  output logic                     done
);

  localparam int G   = 128 / LANES;
  localparam int DW  = LANES * 2 * W;
  localparam int KW1 = K_W + 1;
  localparam logic [K_W:0]       KMAX_C = KW1'(K_MAX);
  localparam logic [GRP_W-1:0]   GLAST  = GRP_W'(G - 1);

  state_t state_q, state_d;
  logic [GRP_W-1:0] g_q, g_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [K_W:0]     n_q, n_d;
  meta_t            meta_q [5];
  meta_t            meta_d [5];
  logic             av_q, av_d, al_q, al_d;
  logic [GRP_W-1:0] ag_q, ag_d;
  logic signed [19:0] acc_q [LANES][2];
  logic signed [19:0] acc_d [LANES][2];
  logic             r_we_q, r_we_d;
  logic [GRP_W-1:0] r_addr_q, r_addr_d;
  logic [DW-1:0]    r_wdata_q, r_wdata_d;
  logic             issue, k_last;
  logic [LANES-1:0] ov;
  logic signed [W-1:0] pr0 [LANES];
  logic signed [W-1:0] pr1 [LANES];

  assign issue  = state_q == S_ISSUE;
  assign k_last = {1'b0, k_q} == n_q - 1'b1;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    k_d     = k_q;
    n_d     = n_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        g_d     = '0;
        k_d     = '0;
        n_d     = (poly_cnt > KMAX_C) ? KMAX_C : poly_cnt;
        state_d = (poly_cnt == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (k_last) begin
          k_d = '0;
          if (g_q == GLAST) state_d = S_DRAIN;
          else g_d = g_q + 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      // Finished once the last group leaves the accumulator.
      S_DRAIN: if (av_q && al_q && ag_q == GLAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    meta_d[0].vld   = issue;
    meta_d[0].first = k_q == '0;
    meta_d[0].last  = k_last;
    meta_d[0].grp   = 7'(g_q);
    for (int i = 1; i < 5; i++) meta_d[i] = meta_q[i-1];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [6:0]          pair;
    logic signed [W-1:0] zraw;
    logic signed [W-1:0] zeta;

    assign pair = 7'(int'(meta_q[0].grp) * LANES + l);
    assign zraw = W'(ZETAS[{1'b1, pair[6:1]}]);
    assign zeta = pair[0] ? -zraw : zraw;

    basemul_pipe #(.W(W)) u_bm (
      .clk       (clk),
      .rst       (rst),
      .a0        (a_rdata[l*2*W +: W]),
      .a1        (a_rdata[l*2*W+W +: W]),
      .b0        (b_rdata[l*2*W +: W]),
      .b1        (b_rdata[l*2*W+W +: W]),
      .zeta      (zeta),
      .in_valid  (meta_q[0].vld),
      .r0        (pr0[l]),
      .r1        (pr1[l]),
      .out_valid (ov[l])
    );
  end

  always_comb begin
    acc_d = acc_q;
    av_d  = meta_q[4].vld & (&ov);
    al_d  = meta_q[4].last;
    ag_d  = GRP_W'(meta_q[4].grp);
    if (av_d) begin
      for (int l = 0; l < LANES; l++) begin
        if (meta_q[4].first) begin
          acc_d[l][0] = 20'(pr0[l]);
          acc_d[l][1] = 20'(pr1[l]);
        end else begin
          acc_d[l][0] = acc_q[l][0] + 20'(pr0[l]);
          acc_d[l][1] = acc_q[l][1] + 20'(pr1[l]);
        end
      end
    end
  end

  always_comb begin
    r_we_d    = av_q & al_q;
    r_addr_d  = r_addr_q;
    r_wdata_d = r_wdata_q;
    if (r_we_d) begin
      r_addr_d = ag_q;
      for (int l = 0; l < LANES; l++) begin
        r_wdata_d[l*2*W +: W]   = W'(barrett_reduce(acc_q[l][0]));
        r_wdata_d[l*2*W+W +: W] = W'(barrett_reduce(acc_q[l][1]));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      g_q       <= '0;
      k_q       <= '0;
      n_q       <= '0;
      av_q      <= 1'b0;
      al_q      <= 1'b0;
      ag_q      <= '0;
      r_we_q    <= 1'b0;
      r_addr_q  <= '0;
      r_wdata_q <= '0;
      for (int i = 0; i < 5; i++) meta_q[i] <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l][0] <= '0;
        acc_q[l][1] <= '0;
      end
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      k_q       <= k_d;
      n_q       <= n_d;
      av_q      <= av_d;
      al_q      <= al_d;
      ag_q      <= ag_d;
      r_we_q    <= r_we_d;
      r_addr_q  <= r_addr_d;
      r_wdata_q <= r_wdata_d;
      meta_q    <= meta_d;
      acc_q     <= acc_d;
    end
  end

  assign a_addr  = {k_q, g_q};
  assign b_addr  = {k_q, g_q};
  assign a_re    = issue;
  assign r_we    = r_we_q;
  assign r_addr  = r_addr_q;
  assign r_wdata = r_wdata_q;
  assign busy    = state_q != S_IDLE;
  assign done    = state_q == S_DONE;

endmodule

// File: tb/tb_poly_basemul_acc.sv
// Randomised and directed bench for poly_basemul_acc against a
// plain-arithmetic model of the Kyber basemul accumulation.
module tb_poly_basemul_acc;

  localparam int LANES = 2;
  localparam int K_MAX = 4;
  localparam int W     = 16;
  localparam int G     = 128 / LANES;
  localparam int GRP_W = $clog2(G);
  localparam int K_W   = $clog2(K_MAX);
  localparam int AW    = K_W + GRP_W;
  localparam int DW    = LANES * 2 * W;
  localparam int Q     = 3329;

  localparam int ZT [128] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [K_W:0] poly_cnt = '0;
  logic [AW-1:0] a_addr, b_addr;
  logic a_re;
  logic [DW-1:0] a_rdata, b_rdata, r_wdata;
  logic [GRP_W-1:0] r_addr;
  logic r_we, busy, done;

  logic [DW-1:0] mem_a [1<<AW];
  logic [DW-1:0] mem_b [1<<AW];
  logic [DW-1:0] exp_w [G];
  logic [DW-1:0] got_w [G];
  int ca [K_MAX][128][2];
  int cb [K_MAX][128][2];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  poly_basemul_acc #(.LANES(LANES), .K_MAX(K_MAX), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .poly_cnt(poly_cnt),
    .a_addr(a_addr), .b_addr(b_addr), .a_re(a_re),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .r_addr(r_addr), .r_wdata(r_wdata), .r_we(r_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (a_re) begin
      a_rdata <= mem_a[a_addr];
      b_rdata <= mem_b[b_addr];
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int fqmul(int x, int y);
    int a, t;
    a = x * y;
    t = (a * -3327) & 'hFFFF;
    if (t >= 32768) t -= 65536;
    return (a - t * Q) / 65536;
  endfunction

  function automatic int barrett(int v);
    return v - ((20159 * v + (1 << 25)) >>> 26) * Q;
  endfunction

  function automatic int coef(int g, int l, int c);
    logic [15:0] h;
    h = got_w[g][l*32 + c*16 +: 16];
    return int'($signed(h));
  endfunction

  // mode 0 random, 1 identity, 2 zeta, 3/4 +/-1664 per term
  task automatic fill(input int mode);
    for (int k = 0; k < K_MAX; k++) begin
      for (int p = 0; p < 128; p++) begin
        case (mode)
          1: begin ca[k][p] = '{2285, 0}; cb[k][p] = '{5, 7}; end
          2: begin ca[k][p] = '{0, 2285}; cb[k][p] = '{0, 2285}; end
          3: begin ca[k][p] = '{2285, 0}; cb[k][p] = '{1664, 0}; end
          4: begin ca[k][p] = '{2285, 0}; cb[k][p] = '{-1664, 0}; end
          default: begin
            for (int c = 0; c < 2; c++) begin
              ca[k][p][c] = int'($urandom_range(0, 6656)) - 3328;
              cb[k][p][c] = int'($urandom_range(0, 6656)) - 3328;
            end
          end
        endcase
      end
      for (int g = 0; g < G; g++) begin
        for (int l = 0; l < LANES; l++) begin
          mem_a[k*G+g][l*32 +: 16]      = 16'(ca[k][g*LANES+l][0]);
          mem_a[k*G+g][l*32+16 +: 16]   = 16'(ca[k][g*LANES+l][1]);
          mem_b[k*G+g][l*32 +: 16]      = 16'(cb[k][g*LANES+l][0]);
          mem_b[k*G+g][l*32+16 +: 16]   = 16'(cb[k][g*LANES+l][1]);
        end
      end
    end
  endtask

  task automatic build_expect(input int n);
    int r0, r1, z;
    for (int p = 0; p < 128; p++) begin
      r0 = 0;
      r1 = 0;
      z = (p % 2 == 1) ? -ZT[64 + p/2] : ZT[64 + p/2];
      for (int k = 0; k < n; k++) begin
        r0 += fqmul(fqmul(ca[k][p][1], cb[k][p][1]), z)
            + fqmul(ca[k][p][0], cb[k][p][0]);
        r1 += fqmul(ca[k][p][0], cb[k][p][1])
            + fqmul(ca[k][p][1], cb[k][p][0]);
      end
      exp_w[p/LANES][(p%LANES)*32 +: 16]    = 16'(barrett(r0));
      exp_w[p/LANES][(p%LANES)*32+16 +: 16] = 16'(barrett(r1));
    end
  endtask

  task automatic run_job(input int req, input bit again);
    int n, c0, rel, nrd, nwr, dcyc, eg, ek;
    n = (req > K_MAX) ? K_MAX : req;
    build_expect(n);
    for (int g = 0; g < G; g++) got_w[g] = '0;
    @(negedge clk);
    start = 1'b1;
    poly_cnt = req[K_W:0];
    c0 = cyc;
    nrd = 0;
    nwr = 0;
    dcyc = -1;
    for (int i = 0; i < G*K_MAX + 40 && dcyc < 0; i++) begin
      @(negedge clk);
      rel = cyc - c0;
      start = again && rel == 3;
      if (rel == 1 && n > 0) check("busy_on", busy, 1);
      if (a_re) begin
        if (n > 0) begin
          eg = nrd / n;
          ek = nrd % n;
          check("rd_addr_a", a_addr, ek*G + eg);
          check("rd_addr_b", b_addr, ek*G + eg);
        end
        nrd++;
      end
      if (r_we) begin
        if (nwr < G) begin
          got_w[nwr] = r_wdata;
          check("wr_addr", r_addr, nwr);
          check("wr_data", r_wdata, exp_w[nwr]);
          check("wr_cycle", rel, nwr*n + n + 7);
        end
        nwr++;
      end
      if (done) dcyc = rel;
    end
    start = 1'b0;
    check("done_cycle", dcyc, (n == 0) ? 1 : G*n + 7);
    check("reads", nrd, G*n);
    check("writes", nwr, (n == 0) ? 0 : G);
    @(negedge clk);
    check("idle_after", {busy, done, a_re, r_we}, 0);
  endtask

  task automatic reset_mid();
    int c0, bad;
    fill(0);
    @(negedge clk);
    start = 1'b1;
    poly_cnt = 2;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc - c0 < 50) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_ctl", {a_re, r_we, busy, done}, 0);
    check("rst_addr", {a_addr, r_addr}, 0);
    check("rst_wdata", r_wdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (r_we || a_re || busy) bad++;
    end
    check("rst_quiet", bad, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_ctl", {a_re, r_we, busy, done}, 0);
    check("reset_data", {a_addr, r_addr, r_wdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ctl", {a_re, r_we, busy, done}, 0);

    fill(1);
    run_job(1, 1'b0);
    check("ident_r0", coef(0, 0, 0), 5);
    check("ident_r1", coef(0, 0, 1), 7);
    check("ident_last", coef(G-1, 1, 1), 7);

    fill(2);
    run_job(1, 1'b0);
    check("zeta_p0", coef(0, 0, 0), -1103);
    check("zeta_p1", coef(0, 1, 0), 1103);
    check("zeta_p1_r1", coef(0, 1, 1), 0);
    check("zeta_p2", coef(1, 0, 0), 430);
    check("zeta_p3", coef(1, 1, 0), -430);

    fill(1);
    run_job(3, 1'b0);
    check("acc_r0", coef(5, 1, 0), 15);
    check("acc_r1", coef(5, 1, 1), 21);

    fill(3);
    run_job(3, 1'b0);
    check("wrap_pos", coef(7, 0, 0), 1663);
    fill(4);
    run_job(3, 1'b0);
    check("wrap_neg", coef(9, 1, 0), -1663);

    fill(0);
    run_job(3, 1'b1);
    run_job(0, 1'b0);
    fill(0);
    run_job(7, 1'b0);
    for (int r = 1; r <= K_MAX; r++) begin
      fill(0);
      run_job(r, 1'b0);
    end

    reset_mid();
    fill(0);
    run_job(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
